// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit registered ALU.
// Opcode encoding, datapath widths and the reserved-opcode test.
package alu_pkg;

  localparam int ALU_W  = 8;
  localparam int ALU_CW = 4;

  typedef enum logic [ALU_CW-1:0] {
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_ASR  = 4'hC,
    OP_NOT  = 4'hD
  } alu_op_e;

  // Reserved codes 0x0, 0xE and 0xF produce a cleared result.
  function automatic logic alu_op_valid(input logic [ALU_CW-1:0] op);
    return (op >= 4'h1) && (op <= 4'hD);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the datapath and the ALU stage.
// The master drives the operation; the slave returns the registered result.
interface alu_if;
  import alu_pkg::*;

  logic [ALU_CW-1:0] C;
  logic [ALU_W-1:0]  A;
  logic [ALU_W-1:0]  B;
  logic [ALU_W-1:0]  s;
  logic              cout;

  modport master (output C, output A, output B, input s, input cout);
  modport slave  (input C, input A, input B, output s, output cout);

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode decode, 9-bit add/sub, logic and
// shift/rotate results selected into the next result and carry bit.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_CW-1:0] i_op,
  input  logic [ALU_W-1:0]  i_a,
  input  logic [ALU_W-1:0]  i_b,
  output logic [ALU_W-1:0]  o_s,
  output logic              o_cout
);

  logic [ALU_W:0]   w_sum;
  logic [ALU_W:0]   w_diff;
  logic [ALU_W-1:0] w_s;
  logic             w_cout;
  alu_op_e          w_op;

  assign w_op   = alu_op_e'(i_op);
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Bit 8 of the zero-extended difference is set exactly when A < B.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    w_s    = '0;
    w_cout = 1'b0;
    if (alu_op_valid(i_op)) begin
      case (w_op)
        OP_ADD:  {w_cout, w_s} = w_sum;
        OP_SUB:  {w_cout, w_s} = w_diff;
        OP_AND:  w_s = i_a & i_b;
        OP_OR:   w_s = i_a | i_b;
        OP_XOR:  w_s = i_a ^ i_b;
        OP_NAND: w_s = ~(i_a & i_b);
        OP_NOR:  w_s = ~(i_a | i_b);
        OP_SHL:  begin w_s = {i_a[ALU_W-2:0], 1'b0};     w_cout = i_a[ALU_W-1]; end
        OP_SHR:  begin w_s = {1'b0, i_a[ALU_W-1:1]};     w_cout = i_a[0];       end
        OP_ROL:  begin w_s = {i_a[ALU_W-2:0], i_a[ALU_W-1]}; w_cout = i_a[ALU_W-1]; end
        OP_ROR:  begin w_s = {i_a[0], i_a[ALU_W-1:1]};   w_cout = i_a[0];       end
        OP_ASR:  begin w_s = {i_a[ALU_W-1], i_a[ALU_W-1:1]}; w_cout = i_a[0];   end
        OP_NOT:  w_s = ~i_a;
        default: begin w_s = '0; w_cout = 1'b0; end
      endcase
    end
  end

  assign o_s    = w_s;
  assign o_cout = w_cout;

endmodule

// File: rtl/alu.sv
// Single-cycle execute stage: combinational ALU core followed by the
// 9-bit result/carry register with synchronous active-low reset.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [ALU_W-1:0] w_s_nxt;
  logic             w_cout_nxt;
  logic [ALU_W-1:0] r_s;
  logic             r_cout;

  alu_core u_core (
    .i_op   (bus.C),
    .i_a    (bus.A),
    .i_b    (bus.B),
    .o_s    (w_s_nxt),
    .o_cout (w_cout_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_s_nxt;
      r_cout <= w_cout_nxt;
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered ALU: integer-arithmetic reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_alu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic chk_en;
  logic [8:0] exp_q;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {cout, s} computed with plain integer arithmetic.
  function automatic logic [8:0] model(input int op, input int a, input int b);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      1:  begin r = (a + b) % 256;       c = ((a + b) > 255) ? 1 : 0; end
      2:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;        end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 255 - (a & b);
      7:  r = 255 - (a | b);
      8:  begin r = (a * 2) % 256;               c = a / 128; end
      9:  begin r = a / 2;                       c = a % 2;   end
      10: begin r = (a * 2) % 256 + a / 128;     c = a / 128; end
      11: begin r = a / 2 + (a % 2) * 128;       c = a % 2;   end
      12: begin r = a / 2 + (a / 128) * 128;     c = a % 2;   end
      13: r = 255 - a;
      default: begin r = 0; c = 0; end
    endcase
    return {c[0], r[7:0]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) exp_q <= 9'h000;
    else        exp_q <= model(int'(bus.C), int'(bus.A), int'(bus.B));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({bus.cout, bus.s} !== exp_q) begin
        bad++;
        $display("FAIL cycle_model: got cout=%b s=%02h, want cout=%b s=%02h (C=%h A=%02h B=%02h)",
                 bus.cout, bus.s, exp_q[8], exp_q[7:0], bus.C, bus.A, bus.B);
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.C = op;
    bus.A = a;
    bus.B = b;
  endtask

  // Apply one op, then check the result one edge later against literals.
  task automatic check_op(input string name, input logic [3:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec);
    logic [8:0] m;
    drive(op, a, b);
    @(posedge clk);
    #1;
    total++;
    if (bus.s !== es || bus.cout !== ec) begin
      bad++;
      $display("FAIL %s: got s=%02h cout=%b, want s=%02h cout=%b", name, bus.s, bus.cout, es, ec);
    end
    m = model(int'(op), int'(a), int'(b));
    total++;
    if (m !== {ec, es}) begin
      bad++;
      $display("FAIL %s_model: model s=%02h cout=%b, want s=%02h cout=%b", name, m[7:0], m[8], es, ec);
    end
  endtask

  task automatic check_reset_out(input string name);
    total++;
    if (bus.s !== 8'h00 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL %s: got s=%02h cout=%b, want s=00 cout=0", name, bus.s, bus.cout);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    drive(4'h1, 8'hFF, 8'hFF);

    @(posedge clk); #1;
    chk_en = 1'b1;
    check_reset_out("reset_c1");
    @(posedge clk); #1;
    check_reset_out("reset_c2");

    rst_n = 1'b1;
    check_op("reset_release_add", 4'h1, 8'hFF, 8'hFF, 8'hFE, 1'b1);

    check_op("add_32_32", 4'h1, 8'h32, 8'h32, 8'h64, 1'b0);
    check_op("add_ce_b5", 4'h1, 8'hCE, 8'hB5, 8'h83, 1'b1);
    check_op("add_64_9c", 4'h1, 8'h64, 8'h9C, 8'h00, 1'b1);

    check_op("sub_32_4b", 4'h2, 8'h32, 8'h4B, 8'hE7, 1'b1);
    check_op("sub_00_fe", 4'h2, 8'h00, 8'hFE, 8'h02, 1'b1);
    check_op("sub_32_32", 4'h2, 8'h32, 8'h32, 8'h00, 1'b0);

    check_op("and",  4'h3, 8'hCE, 8'hB5, 8'h84, 1'b0);
    check_op("or",   4'h4, 8'hCE, 8'hB5, 8'hFF, 1'b0);
    check_op("xor",  4'h5, 8'hCE, 8'hB5, 8'h7B, 1'b0);
    check_op("nand", 4'h6, 8'hCE, 8'hB5, 8'h7B, 1'b0);
    check_op("nor",  4'h7, 8'hCE, 8'hB5, 8'h00, 1'b0);

    check_op("shl",    4'h8, 8'hCD, 8'h5A, 8'h9A, 1'b1);
    check_op("shr",    4'h9, 8'hCD, 8'h5A, 8'h66, 1'b1);
    check_op("rol",    4'hA, 8'hCD, 8'h5A, 8'h9B, 1'b1);
    check_op("ror",    4'hB, 8'hCD, 8'h5A, 8'hE6, 1'b1);
    check_op("asr",    4'hC, 8'hCD, 8'h5A, 8'hE6, 1'b1);
    check_op("not",    4'hD, 8'hCD, 8'h5A, 8'h32, 1'b0);
    check_op("rol_55", 4'hA, 8'h55, 8'hFF, 8'hAA, 1'b0);
    check_op("asr_pos", 4'hC, 8'h4B, 8'h00, 8'h25, 1'b1);
    check_op("shl_b_ignored", 4'h8, 8'h41, 8'hFF, 8'h82, 1'b0);

    check_op("rsv_0", 4'h0, 8'hFF, 8'h01, 8'h00, 1'b0);
    check_op("rsv_e", 4'hE, 8'hFF, 8'h01, 8'h00, 1'b0);
    check_op("rsv_f", 4'hF, 8'hFF, 8'h01, 8'h00, 1'b0);

    // Back-to-back: a new opcode every cycle, checked by the cycle model.
    for (int rep = 0; rep < 4; rep++) begin
      for (int op = 1; op <= 15; op++) begin
        drive(4'(op), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        @(posedge clk); #1;
      end
    end

    // Reset asserted mid-stream discards the op sampled at that edge.
    drive(4'h1, 8'hF0, 8'h20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_out("reset_midstream");
    rst_n = 1'b1;
    check_op("after_mid_reset", 4'h2, 8'h10, 8'h20, 8'hF0, 1'b1);

    @(posedge clk); #1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
